// File: rtl/fifo_sync_pkg.sv
// Shared helpers for async FIFO pointer synchronisers.
// Gray/binary conversion and single-bit-change detection.
package fifo_sync_pkg;

  localparam int MIN_SYNC_STAGES = 2;
  localparam int MAX_SYNC_STAGES = 4;
  localparam int PTR_MAXW        = 32;

  typedef logic [PTR_MAXW-1:0] ptr_wide_t;

  // Callers zero-extend narrower pointers; leading zeros convert to zeros.
  function automatic ptr_wide_t gray2bin(input ptr_wide_t g);
    ptr_wide_t b;
    b[PTR_MAXW-1] = g[PTR_MAXW-1];
    for (int i = PTR_MAXW-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic ptr_wide_t bin2gray(input ptr_wide_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic onehot0_change(
    input ptr_wide_t a,
    input ptr_wide_t b
  );
    ptr_wide_t d;
    int        n;
    d = a ^ b;
    n = 0;
    for (int i = 0; i < PTR_MAXW; i++) begin
      n += int'(d[i]);
    end
    return n <= 1;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Generic N-flop bus synchroniser.
// Async active-low reset, synchronous clear.
module sync_chain #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s [STAGES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < STAGES; i++) begin
        s[i] <= '0;
      end
    end else if (clr) begin
      for (int i = 0; i < STAGES; i++) begin
        s[i] <= '0;
      end
    end else begin
      s[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        s[i] <= s[i-1];
      end
    end
  end

  assign q = s[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync.sv
// Gray pointer synchroniser for async FIFOs.
// Registered Gray/binary outputs, update pulse, flush refill, error flag.
module gray_ptr_sync
  import fifo_sync_pkg::*;
#(
  parameter int ADDRBITS  = 8,
  parameter int STAGES    = 2,
  parameter int ERR_CHECK = 1
) (
  input  logic              clk_out,
  input  logic              rst,
  input  logic              sync_flush,
  input  logic [ADDRBITS:0] gray_ptr_in,
  input  logic              err_clr,
  output logic [ADDRBITS:0] sync_gray_ptr,
  output logic [ADDRBITS:0] sync_bin_ptr,
  output logic              ptr_update,
  output logic              flush_busy,
  output logic              gray_err
);

  localparam int PW = ADDRBITS + 1;
  localparam int CW = $clog2(MAX_SYNC_STAGES + 2);
  localparam logic [CW-1:0] REFILL = CW'(STAGES + 1);

  if (STAGES < MIN_SYNC_STAGES || STAGES > MAX_SYNC_STAGES) begin : g_bad_stages
    $error("gray_ptr_sync: STAGES must be 2..4");
  end
  if (PW > PTR_MAXW) begin : g_bad_width
    $error("gray_ptr_sync: pointer too wide");
  end

  logic [PW-1:0] s_last;
  logic [PW-1:0] bin_next;
  logic [CW-1:0] refill_cnt;
  logic          changed;
  logic          cmp_valid;

  sync_chain #(
    .WIDTH  (PW),
    .STAGES (STAGES)
  ) u_chain (
    .clk (clk_out),
    .rst (rst),
    .clr (sync_flush),
    .d   (gray_ptr_in),
    .q   (s_last)
  );

  assign bin_next   = PW'(gray2bin(PTR_MAXW'(s_last)));
  assign changed    = s_last != sync_gray_ptr;
  assign flush_busy = refill_cnt != '0;

  // cmp_valid drops across a flush so the refill jump is not an error.
  always_ff @(posedge clk_out or negedge rst) begin
    if (!rst) begin
      sync_gray_ptr <= '0;
      sync_bin_ptr  <= '0;
      ptr_update    <= 1'b0;
      refill_cnt    <= '0;
      cmp_valid     <= 1'b1;
    end else if (sync_flush) begin
      sync_gray_ptr <= '0;
      sync_bin_ptr  <= '0;
      ptr_update    <= 1'b0;
      refill_cnt    <= REFILL;
      cmp_valid     <= 1'b0;
    end else if (flush_busy) begin
      sync_gray_ptr <= '0;
      sync_bin_ptr  <= '0;
      ptr_update    <= 1'b0;
      refill_cnt    <= refill_cnt - 1'b1;
    end else begin
      sync_gray_ptr <= s_last;
      sync_bin_ptr  <= bin_next;
      ptr_update    <= changed;
      cmp_valid     <= 1'b1;
    end
  end

  if (ERR_CHECK != 0) begin : g_err
    logic multi;
    logic err_set;

    assign multi   = !onehot0_change(PTR_MAXW'(s_last),
                                     PTR_MAXW'(sync_gray_ptr));
    assign err_set = multi && cmp_valid && !sync_flush && !flush_busy;

    always_ff @(posedge clk_out or negedge rst) begin
      if (!rst) begin
        gray_err <= 1'b0;
      end else if (err_set) begin
        gray_err <= 1'b1;
      end else if (err_clr) begin
        gray_err <= 1'b0;
      end
    end
  end else begin : g_no_err
    assign gray_err = 1'b0;
  end

endmodule
